// File: rtl/binary_mul_seq_booth.sv
// binary_mul_seq_booth: iterative radix-2 Booth multiplier, signed/unsigned, valid/ready handshakes
module binary_mul_seq_booth #(
    parameter int WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 en,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic                 is_signed,
    input  logic [WIDTH-1:0]     A,
    input  logic [WIDTH-1:0]     B,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2*WIDTH-1:0]   P,
    output logic                 busy
);
    localparam int CW = $clog2(WIDTH + 2);
    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
    state_t             r_state, w_next;
    logic [WIDTH+1:0]   r_acc, w_mc_ext, w_sum, w_acc_n;
    logic [WIDTH:0]     r_mc, r_mq, w_mq_n;
    logic               r_q1, w_last;
    logic [CW-1:0]      r_cnt;
    logic [2*WIDTH-1:0] r_p;
    assign w_mc_ext = {r_mc[WIDTH], r_mc};
    assign w_sum    = ({r_mq[0], r_q1} == 2'b01) ? r_acc + w_mc_ext :
                      ({r_mq[0], r_q1} == 2'b10) ? r_acc - w_mc_ext : r_acc;
    assign w_acc_n  = {w_sum[WIDTH+1], w_sum[WIDTH+1:1]};
    assign w_mq_n   = {w_sum[0], r_mq[WIDTH:1]};
    assign w_last   = r_cnt == CW'(WIDTH);
    assign in_ready  = r_state == IDLE;
    assign out_valid = r_state == DONE;
    assign busy      = r_state != IDLE;
    assign P         = r_p;
    always_comb begin
        w_next = (r_state == IDLE && in_valid)        ? CALC :
                 (r_state == CALC && en && w_last)    ? DONE :
                 (r_state == DONE && out_ready)       ? IDLE : r_state;
    end
    always_ff @(posedge clk) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_next;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            r_acc <= '0;
            r_mc  <= '0;
            r_mq  <= '0;
            r_q1  <= 1'b0;
            r_cnt <= '0;
            r_p   <= '0;
        end else if (r_state == IDLE && in_valid) begin
            r_mc  <= {is_signed & A[WIDTH-1], A};
            r_mq  <= {is_signed & B[WIDTH-1], B};
            r_acc <= '0;
            r_q1  <= 1'b0;
            r_cnt <= '0;
        end else if (r_state == CALC && en) begin
            r_acc <= w_acc_n;
            r_mq  <= w_mq_n;
            r_q1  <= r_mq[0];
            r_cnt <= r_cnt + 1'b1;
            if (w_last) r_p <= {w_acc_n[WIDTH-2:0], w_mq_n};
        end
    end
endmodule
